fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter addr_ins_width, default 32, PC, address and instruction width in bits.
REQ-002 SHALL have parameter memory_height, default 512, number of instruction-memory words.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, byte address loaded into the PC by reset.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 port clk  input  1  clock; all state updates on rising edge.
REQ-006 port rst  input  1  synchronous active-high reset.
REQ-007 port imem_addr  output  addr_ins_width  instruction-memory word index, equal to pc >> 2, combinational from PC.
REQ-008 port imem_instr  input  addr_ins_width  instruction word returned combinationally for imem_addr.
REQ-009 port redirect_valid  input  1  branch/jump redirect request from execute.
REQ-010 port redirect_target  input  addr_ins_width  redirect byte address.
REQ-011 port out_valid  output  1  buffer head holds a valid instruction for decode.
REQ-012 port out_ready  input  1  decode accepts the head this cycle.
REQ-013 port out_instr  output  addr_ins_width  head instruction word.
REQ-014 port out_pc  output  addr_ins_width  byte address of head instruction.
REQ-015 port done  output  1  PC has passed the last memory word; fetching stopped.
REQ-016 port fetch_err  output  1  one-cycle pulse: misaligned redirect target received.

Function
REQ-017 SHALL hold a byte-address PC register and a 2-entry FIFO of {pc, instr} pairs with read pointer, write pointer and 2-bit count.
REQ-018 Pop SHALL occur on a cycle with out_valid && out_ready; head advances at the next edge.
REQ-019 Push SHALL occur when no redirect, done == 0, and (count < 2 or pop this cycle); pushed pair is {pc, imem_instr}; pc <= pc + 4 in the same edge.
REQ-020 Full FIFO with simultaneous pop SHALL push and pop in the same cycle; count stays 2.
REQ-021 Full FIFO without pop SHALL hold PC and FIFO unchanged (stall); no instruction is lost or duplicated.
REQ-022 Redirect SHALL take priority over push and pop: FIFO flushed (count <= 0, pointers <= 0), pc <= {redirect_target[addr_ins_width-1:2], 2'b00}, done <= 0.
REQ-023 When redirect_valid && redirect_target[1:0] != 0, fetch_err SHALL be 1 for the next cycle only; the redirect is still taken, aligned down.
REQ-024 out_valid SHALL equal (count != 0); out_instr and out_pc SHALL be 0 when count == 0.
REQ-025 Fetch-to-decode latency SHALL be one cycle: an instruction pushed at edge N is visible on out_* after edge N.
REQ-026 When a push makes (pc + 4) >> 2 equal to memory_height, done SHALL be set at that edge; while done == 1 no pushes occur and PC holds; FIFO continues to drain.
REQ-027 PC arithmetic SHALL wrap modulo 2^addr_ins_width; no overflow flag.

Reset
REQ-028 On rst at a rising edge: pc <= RESET_PC, FIFO flushed, done <= 0, fetch_err <= 0; out_valid == 0 on the following cycle.
REQ-029 rst SHALL override redirect, push and pop in the same cycle, including mid-stall and mid-drain.

Verification
REQ-030 Reset release, out_ready = 1, imem_instr driven per index: out_pc sequence 0, 4, 8 on consecutive cycles starting 1 cycle after reset; imem_addr 0, 1, 2.
REQ-031 out_ready = 0 for 5 cycles after reset: count reaches 2 after 2 edges, PC holds at 8, out_pc stays 0; raising out_ready yields 0, 4, 8 with no gaps or duplicates.
REQ-032 redirect_valid = 1, target 32'h40 while FIFO full: next cycle out_valid = 0, imem_addr = 16; following cycle out_pc = 32'h40.
REQ-033 Redirect to 32'h43: fetch_err = 1 for exactly one cycle; subsequent out_pc = 32'h40.
REQ-034 Redirect to 32'h7FC (word 511) with out_ready = 1: one instruction out_pc = 32'h7FC, done = 1, no further out_valid; redirect to 0 clears done.
REQ-035 rst asserted while FIFO holds 2 entries and redirect_valid = 1: next cycle out_valid = 0, imem_addr = 0, fetch_err = 0, done = 0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: PC generator feeding a 2-entry {pc, instr} buffer toward decode.
// Handles redirects from execute (flush + realign) and stops fetching once the
// PC runs past the last instruction-memory word.
module fetch_unit #(
   parameter int                        addr_ins_width = 32,
   parameter int                        memory_height  = 512,
   parameter logic [addr_ins_width-1:0] RESET_PC       = 32'h0000_0000
) (
   input  logic                      clk,
   input  logic                      rst,
   output logic [addr_ins_width-1:0] imem_addr,
   input  logic [addr_ins_width-1:0] imem_instr,
   input  logic                      redirect_valid,
   input  logic [addr_ins_width-1:0] redirect_target,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [addr_ins_width-1:0] out_instr,
   output logic [addr_ins_width-1:0] out_pc,
   output logic                      done,
   output logic                      fetch_err
);

   localparam int W = addr_ins_width;

   typedef struct packed {
      logic [W-1:0] pc;
      logic [W-1:0] instr;
   } fetch_ent_t;

   fetch_ent_t   fifo_q [2];
   logic         rd_ptr, wr_ptr;
   logic [1:0]   count;
   logic [W-1:0] pc, pc_inc;
   logic         pop, push, last_word;

   // Handshake decode: a full buffer can still accept when the head leaves.
   always_comb begin
      pc_inc    = pc + W'(4);
      pop       = (count != 2'd0) && out_ready;
      push      = !redirect_valid && !done && ((count < 2'd2) || pop);
      last_word = (pc_inc >> 2) == W'(memory_height);
   end

   assign imem_addr = pc >> 2;
   assign out_valid = (count != 2'd0);
   assign out_instr = out_valid ? fifo_q[rd_ptr].instr : '0;
   assign out_pc    = out_valid ? fifo_q[rd_ptr].pc    : '0;

   // Buffer storage; contents are don't-care once the count is flushed.
   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr] <= '{pc: pc, instr: imem_instr};
   end

   // PC, pointers, count and status; reset beats redirect beats push/pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc        <= RESET_PC;
         rd_ptr    <= 1'b0;
         wr_ptr    <= 1'b0;
         count     <= 2'd0;
         done      <= 1'b0;
         fetch_err <= 1'b0;
      end else if (redirect_valid) begin
         pc        <= {redirect_target[W-1:2], 2'b00};
         rd_ptr    <= 1'b0;
         wr_ptr    <= 1'b0;
         count     <= 2'd0;
         done      <= 1'b0;
         fetch_err <= |redirect_target[1:0];
      end else begin
         fetch_err <= 1'b0;
         if (push) begin
            wr_ptr <= ~wr_ptr;
            pc     <= pc_inc;
            if (last_word) done <= 1'b1;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule
